// File: rtl/mapper_mem_arb_if.sv
// Client (PRG/CHR) and external-memory signals of mapper_mem_arb.
// The slave modport is the arbiter's view; master is the view of the surrounding logic.
interface mapper_mem_arb_if;
    logic        prg_req;
    logic [21:0] prg_addr;
    logic        prg_we;
    logic [7:0]  prg_wdata;
    logic        prg_allow;
    logic [7:0]  prg_rdata;
    logic        prg_done;

    logic        chr_req;
    logic [21:0] chr_addr;
    logic        chr_we;
    logic [7:0]  chr_wdata;
    logic        chr_allow;
    logic [7:0]  chr_rdata;
    logic        chr_done;

    logic        mem_req;
    logic [21:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;

    logic        err_timeout;
    logic        err_overrun;

    modport slave (
        input  prg_req, prg_addr, prg_we, prg_wdata, prg_allow,
        input  chr_req, chr_addr, chr_we, chr_wdata, chr_allow,
        input  mem_ack, mem_rdata,
        output prg_rdata, prg_done, chr_rdata, chr_done,
        output mem_req, mem_addr, mem_we, mem_wdata,
        output err_timeout, err_overrun
    );

    modport master (
        output prg_req, prg_addr, prg_we, prg_wdata, prg_allow,
        output chr_req, chr_addr, chr_we, chr_wdata, chr_allow,
        output mem_ack, mem_rdata,
        input  prg_rdata, prg_done, chr_rdata, chr_done,
        input  mem_req, mem_addr, mem_we, mem_wdata,
        input  err_timeout, err_overrun
    );
endinterface

// File: rtl/mapper_mem_arb.sv
// Serialises mapper PRG/CHR accesses onto one SDRAM request/ack port, CHR first with bounded PRG starvation.
// Define MAPPER_MEM_ARB_STATS_EN to add grant counters and a maximum-wait statistic.
module mapper_mem_arb #(
    parameter int         TIMEOUT  = 64,
    parameter int         FAIR_MAX = 2,
    parameter logic [7:0] OPEN_BUS = 8'hFF
) (
    input  logic            clk,
    input  logic            reset_n,
    mapper_mem_arb_if.slave bus
`ifdef MAPPER_MEM_ARB_STATS_EN
    ,
    output logic [15:0]     stat_prg_grants,
    output logic [15:0]     stat_chr_grants,
    output logic [7:0]      stat_max_wait
`endif
);
    localparam logic PRG = 1'b0;
    localparam logic CHR = 1'b1;

    typedef enum logic {IDLE, WAIT} state_t;
    state_t state_reg, state_next;

    logic [1:0]  req_in, we_in, allow_in;
    logic [21:0] addr_in [2];
    logic [7:0]  wdata_in [2];

    logic [1:0]  pend, slot_we, slot_allow, slot_clr, done;
    logic [21:0] slot_addr [2];
    logic [7:0]  slot_wdata [2];
    logic [7:0]  rdata [2];

    logic        cur_reg;
    logic        mem_req_reg, mem_we_reg;
    logic [21:0] mem_addr_reg;
    logic [7:0]  mem_wdata_reg;
    logic [2:0]  fair_cnt_reg;
    logic [7:0]  tmo_cnt_reg;
    logic        err_timeout_reg, err_overrun_reg;

    logic        grant, grant_id, grant_mem, ack_hit, abort, overrun_hit;

    assign req_in      = {bus.chr_req,   bus.prg_req};
    assign we_in       = {bus.chr_we,    bus.prg_we};
    assign allow_in    = {bus.chr_allow, bus.prg_allow};
    assign addr_in[0]  = bus.prg_addr;
    assign addr_in[1]  = bus.chr_addr;
    assign wdata_in[0] = bus.prg_wdata;
    assign wdata_in[1] = bus.chr_wdata;

    // A slot may be refilled on the very edge it completes, so a client that
    // re-requests back to back keeps its place in the arbitration.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_client
            logic        pend_reg, we_reg, allow_reg, done_reg;
            logic [21:0] addr_reg;
            logic [7:0]  wdata_reg, rdata_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    pend_reg  <= 1'b0;
                    we_reg    <= 1'b0;
                    allow_reg <= 1'b0;
                    addr_reg  <= '0;
                    wdata_reg <= '0;
                    done_reg  <= 1'b0;
                    rdata_reg <= '0;
                end else begin
                    if (req_in[gi] && (!pend_reg || slot_clr[gi])) begin
                        pend_reg  <= 1'b1;
                        we_reg    <= we_in[gi];
                        allow_reg <= allow_in[gi];
                        addr_reg  <= addr_in[gi];
                        wdata_reg <= wdata_in[gi];
                    end else if (slot_clr[gi]) begin
                        pend_reg <= 1'b0;
                    end
                    done_reg <= slot_clr[gi];
                    if (slot_clr[gi]) begin
                        // Clearing from IDLE means a disallowed access; from WAIT it is ack or abort.
                        if (state_reg == IDLE || abort)
                            rdata_reg <= OPEN_BUS;
                        else if (!we_reg)
                            rdata_reg <= bus.mem_rdata;
                    end
                end
            end

            assign pend[gi]       = pend_reg;
            assign slot_we[gi]    = we_reg;
            assign slot_allow[gi] = allow_reg;
            assign slot_addr[gi]  = addr_reg;
            assign slot_wdata[gi] = wdata_reg;
            assign done[gi]       = done_reg;
            assign rdata[gi]      = rdata_reg;
        end
    endgenerate

    assign overrun_hit = |(req_in & pend & ~slot_clr);

    always_comb begin
        state_next = state_reg;
        grant      = 1'b0;
        grant_id   = CHR;
        grant_mem  = 1'b0;
        ack_hit    = 1'b0;
        abort      = 1'b0;
        slot_clr   = 2'b00;
        case (state_reg)
            IDLE: begin
                if (|pend) begin
                    grant = 1'b1;
                    if (pend[PRG] && (!pend[CHR] || fair_cnt_reg == 3'(FAIR_MAX)))
                        grant_id = PRG;
                    grant_mem = slot_allow[grant_id];
                    if (grant_mem)
                        state_next = WAIT;
                    else
                        slot_clr[grant_id] = 1'b1;
                end
            end
            WAIT: begin
                if (bus.mem_ack) begin
                    ack_hit           = 1'b1;
                    state_next        = IDLE;
                    slot_clr[cur_reg] = 1'b1;
                end else if (tmo_cnt_reg == 8'(TIMEOUT - 1)) begin
                    abort             = 1'b1;
                    state_next        = IDLE;
                    slot_clr[cur_reg] = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            cur_reg         <= CHR;
            mem_req_reg     <= 1'b0;
            mem_addr_reg    <= '0;
            mem_we_reg      <= 1'b0;
            mem_wdata_reg   <= '0;
            fair_cnt_reg    <= '0;
            tmo_cnt_reg     <= '0;
            err_timeout_reg <= 1'b0;
            err_overrun_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (grant) begin
                if (grant_id == PRG)
                    fair_cnt_reg <= '0;
                else if (pend[PRG] && fair_cnt_reg != 3'(FAIR_MAX))
                    fair_cnt_reg <= fair_cnt_reg + 3'd1;
            end
            if (grant_mem) begin
                mem_req_reg   <= 1'b1;
                mem_addr_reg  <= slot_addr[grant_id];
                mem_we_reg    <= slot_we[grant_id];
                mem_wdata_reg <= slot_wdata[grant_id];
                cur_reg       <= grant_id;
                tmo_cnt_reg   <= '0;
            end
            if (ack_hit || abort)
                mem_req_reg <= 1'b0;
            else if (state_reg == WAIT)
                tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
            err_timeout_reg <= err_timeout_reg | abort;
            err_overrun_reg <= err_overrun_reg | overrun_hit;
        end
    end

    assign bus.prg_rdata   = rdata[0];
    assign bus.prg_done    = done[0];
    assign bus.chr_rdata   = rdata[1];
    assign bus.chr_done    = done[1];
    assign bus.mem_req     = mem_req_reg;
    assign bus.mem_addr    = mem_addr_reg;
    assign bus.mem_we      = mem_we_reg;
    assign bus.mem_wdata   = mem_wdata_reg;
    assign bus.err_timeout = err_timeout_reg;
    assign bus.err_overrun = err_overrun_reg;

`ifdef MAPPER_MEM_ARB_STATS_EN
    logic [15:0] prg_grants_reg, chr_grants_reg;
    logic [7:0]  max_wait_reg, wait_cur;

    // TIMEOUT never exceeds 255, so the running wait count cannot overflow.
    assign wait_cur = tmo_cnt_reg + 8'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prg_grants_reg <= '0;
            chr_grants_reg <= '0;
            max_wait_reg   <= '0;
        end else begin
            if (grant_mem) begin
                if (grant_id == CHR)
                    chr_grants_reg <= chr_grants_reg + 16'd1;
                else
                    prg_grants_reg <= prg_grants_reg + 16'd1;
            end
            if (state_reg == WAIT && wait_cur > max_wait_reg)
                max_wait_reg <= wait_cur;
        end
    end

    assign stat_prg_grants = prg_grants_reg;
    assign stat_chr_grants = chr_grants_reg;
    assign stat_max_wait   = max_wait_reg;
`endif
endmodule

// File: tb/tb_mapper_mem_arb.sv
// Self-checking bench for mapper_mem_arb: per-client expectation queues plus a grant-order log.
module tb_mapper_mem_arb;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mapper_mem_arb_if bus ();

`ifdef MAPPER_MEM_ARB_STATS_EN
    logic [15:0] stat_prg_grants, stat_chr_grants;
    logic [7:0]  stat_max_wait;
    mapper_mem_arb dut (.clk(clk), .reset_n(reset_n), .bus(bus),
                        .stat_prg_grants(stat_prg_grants), .stat_chr_grants(stat_chr_grants),
                        .stat_max_wait(stat_max_wait));
`else
    mapper_mem_arb dut (.clk(clk), .reset_n(reset_n), .bus(bus));
`endif

    typedef struct {
        logic [21:0] addr;
        logic        we;
        logic [7:0]  wdata;
        logic        allow;
        logic        abort;
    } req_t;

    req_t prg_q[$];
    req_t chr_q[$];
    bit   order_q[$];   // 1 = CHR memory grant, 0 = PRG memory grant

    int checks = 0;
    int errors = 0;
    int prg_done_cnt = 0;
    int chr_done_cnt = 0;
    bit ack_en = 1'b1;
    logic [7:0] prg_last = 8'h00;
    logic [7:0] chr_last = 8'h00;

    function automatic logic [7:0] mem_model(input logic [21:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h78;
    endfunction

    function automatic logic [7:0] exp_rdata(input req_t e, input logic [7:0] last);
        if (!e.allow || e.abort) return 8'hFF;
        if (e.we) return last;
        return mem_model(e.addr);
    endfunction

    // Memory responder: single-cycle ack one cycle after mem_req rises.
    always @(posedge clk) begin
        #1;
        if (ack_en && bus.mem_req && !bus.mem_ack) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = mem_model(bus.mem_addr);
        end else begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 8'h00;
        end
    end

    // Scoreboard: grants are matched against the head of the client queue, done pulses pop it.
    always @(negedge clk) begin
        req_t e;
        logic [7:0] x;
        if (reset_n) begin
            if (bus.mem_req && bus.mem_ack) begin
                order_q.push_back(bus.mem_addr[21]);
                checks++;
                if (bus.mem_addr[21] ? chr_q.size() == 0 : prg_q.size() == 0) begin
                    errors++;
                    $display("FAIL grant_unexpected: addr=%h with no pending expectation", bus.mem_addr);
                end else begin
                    e = bus.mem_addr[21] ? chr_q[0] : prg_q[0];
                    if ({bus.mem_addr, bus.mem_we, bus.mem_wdata} !== {e.addr, e.we, e.wdata}) begin
                        errors++;
                        $display("FAIL grant_fields: got addr=%h we=%b wd=%h, want addr=%h we=%b wd=%h",
                                 bus.mem_addr, bus.mem_we, bus.mem_wdata, e.addr, e.we, e.wdata);
                    end
                end
            end
            if (bus.chr_done) begin
                chr_done_cnt++;
                checks++;
                if (chr_q.size() == 0) begin
                    errors++;
                    $display("FAIL chr_done_unexpected: rdata=%h", bus.chr_rdata);
                end else begin
                    e = chr_q.pop_front();
                    x = exp_rdata(e, chr_last);
                    chr_last = x;
                    $display("%0t DONE chr addr=%h we=%b rdata=%h", $time, e.addr, e.we, bus.chr_rdata);
                    if (bus.chr_rdata !== x) begin
                        errors++;
                        $display("FAIL chr_rdata: got %h want %h (addr %h)", bus.chr_rdata, x, e.addr);
                    end
                end
            end
            if (bus.prg_done) begin
                prg_done_cnt++;
                checks++;
                if (prg_q.size() == 0) begin
                    errors++;
                    $display("FAIL prg_done_unexpected: rdata=%h", bus.prg_rdata);
                end else begin
                    e = prg_q.pop_front();
                    x = exp_rdata(e, prg_last);
                    prg_last = x;
                    $display("%0t DONE prg addr=%h we=%b rdata=%h", $time, e.addr, e.we, bus.prg_rdata);
                    if (bus.prg_rdata !== x) begin
                        errors++;
                        $display("FAIL prg_rdata: got %h want %h (addr %h)", bus.prg_rdata, x, e.addr);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input bit is_chr, input logic [21:0] a, input logic we,
                             input logic [7:0] wd, input logic allow, input bit abort, input bit push);
        req_t e;
        e.addr = a; e.we = we; e.wdata = wd; e.allow = allow; e.abort = abort;
        if (is_chr) begin
            bus.chr_req = 1'b1; bus.chr_addr = a; bus.chr_we = we; bus.chr_wdata = wd; bus.chr_allow = allow;
            if (push) chr_q.push_back(e);
        end else begin
            bus.prg_req = 1'b1; bus.prg_addr = a; bus.prg_we = we; bus.prg_wdata = wd; bus.prg_allow = allow;
            if (push) prg_q.push_back(e);
        end
        $display("%0t REQ %s addr=%h we=%b wd=%h allow=%b", $time, is_chr ? "chr" : "prg", a, we, wd, allow);
        tick();
        if (is_chr) bus.chr_req = 1'b0;
        else        bus.prg_req = 1'b0;
    endtask

    task automatic wait_mem_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.mem_req) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.prg_req = 0; bus.prg_addr = '0; bus.prg_we = 0; bus.prg_wdata = '0; bus.prg_allow = 0;
        bus.chr_req = 0; bus.chr_addr = '0; bus.chr_we = 0; bus.chr_wdata = '0; bus.chr_allow = 0;
        bus.mem_ack = 0; bus.mem_rdata = '0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
        checks++;
        if ({bus.mem_addr, bus.mem_we, bus.mem_wdata} !== 31'd0) begin
            errors++; $display("FAIL reset_mem_bus: got addr=%h we=%b wd=%h want 0", bus.mem_addr, bus.mem_we, bus.mem_wdata);
        end
        checks++;
        if ({bus.prg_done, bus.chr_done} !== 2'b00) begin
            errors++; $display("FAIL reset_done: got %b%b want 00", bus.prg_done, bus.chr_done);
        end
        checks++;
        if ({bus.prg_rdata, bus.chr_rdata} !== 16'h0000) begin
            errors++; $display("FAIL reset_rdata: got %h/%h want 00/00", bus.prg_rdata, bus.chr_rdata);
        end
        checks++;
        if ({bus.err_timeout, bus.err_overrun} !== 2'b00) begin
            errors++; $display("FAIL reset_errs: got %b%b want 00", bus.err_timeout, bus.err_overrun);
        end
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_chr_read();
        drive_req(1'b1, 22'h200123, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL chr_read_early_req: got %b want 0", bus.mem_req); end
        @(negedge clk);
        checks++;
        if ({bus.mem_req, bus.mem_addr, bus.mem_we} !== {1'b1, 22'h200123, 1'b0}) begin
            errors++; $display("FAIL chr_read_mem: got req=%b addr=%h we=%b want 1/200123/0", bus.mem_req, bus.mem_addr, bus.mem_we);
        end
        @(negedge clk);
        checks++;
        if ({bus.chr_done, bus.chr_rdata} !== {1'b1, 8'h5A}) begin
            errors++; $display("FAIL chr_read_done: got done=%b rdata=%h want 1/5a", bus.chr_done, bus.chr_rdata);
        end
        repeat (3) tick();
    endtask

    task automatic test_simultaneous();
        int n0 = order_q.size();
        int pd = prg_done_cnt;
        int cd = chr_done_cnt;
        req_t e;
        e.we = 0; e.wdata = 0; e.allow = 1; e.abort = 0;
        bus.prg_req = 1; bus.prg_addr = 22'h000456; bus.prg_we = 0; bus.prg_wdata = 0; bus.prg_allow = 1;
        bus.chr_req = 1; bus.chr_addr = 22'h2003C0; bus.chr_we = 0; bus.chr_wdata = 0; bus.chr_allow = 1;
        e.addr = 22'h000456; prg_q.push_back(e);
        e.addr = 22'h2003C0; chr_q.push_back(e);
        $display("%0t REQ prg+chr simultaneous", $time);
        tick();
        bus.prg_req = 0; bus.chr_req = 0;
        repeat (10) tick();
        checks++;
        if (order_q.size() != n0 + 2) begin
            errors++; $display("FAIL simul_grants: got %0d grants want 2", order_q.size() - n0);
        end else begin
            checks++;
            if ({order_q[n0], order_q[n0+1]} !== 2'b10) begin
                errors++; $display("FAIL simul_order: got %b%b want 10 (chr then prg)", order_q[n0], order_q[n0+1]);
            end
        end
        checks++;
        if (prg_done_cnt != pd + 1 || chr_done_cnt != cd + 1) begin
            errors++; $display("FAIL simul_dones: got prg=%0d chr=%0d want 1/1", prg_done_cnt - pd, chr_done_cnt - cd);
        end
    endtask

    task automatic test_disallowed();
        int n0 = order_q.size();
        bit saw_req = 0;
        drive_req(1'b0, 22'h001FFF, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        if (bus.mem_req) saw_req = 1;
        @(negedge clk);
        checks++;
        if ({bus.prg_done, bus.prg_rdata} !== {1'b1, 8'hFF}) begin
            errors++; $display("FAIL disallow_done: got done=%b rdata=%h want 1/ff", bus.prg_done, bus.prg_rdata);
        end
        for (int i = 0; i < 4; i++) begin
            if (bus.mem_req) saw_req = 1;
            @(negedge clk);
        end
        checks++;
        if (saw_req || order_q.size() != n0) begin
            errors++; $display("FAIL disallow_no_mem: got mem_req seen=%b grants=%0d want 0/0", saw_req, order_q.size() - n0);
        end
        tick();
    endtask

    task automatic test_overrun();
        bit ok;
        int cd;
        checks++;
        if (bus.err_overrun !== 1'b0) begin errors++; $display("FAIL overrun_pre: got %b want 0", bus.err_overrun); end
        ack_en = 0;
        drive_req(1'b1, 22'h200777, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        wait_mem_req(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL overrun_wait_req: got no mem_req want mem_req within 20 cycles"); end
        cd = chr_done_cnt;
        drive_req(1'b1, 22'h200888, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.err_overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag: got %b want 1", bus.err_overrun); end
        ack_en = 1;
        repeat (8) tick();
        checks++;
        if (chr_done_cnt != cd + 1) begin
            errors++; $display("FAIL overrun_single_done: got %0d chr_done want 1", chr_done_cnt - cd);
        end
    endtask

    task automatic test_fairness();
        int n0 = order_q.size();
        bit exp_order[6] = '{1, 1, 0, 1, 1, 0};
        req_t e;
        e.we = 0; e.wdata = 0; e.allow = 1; e.abort = 0;
        for (int i = 0; i < 20; i++) begin
            e.addr = 22'h000ABC; prg_q.push_back(e);
            e.addr = 22'h200DEF; chr_q.push_back(e);
        end
        bus.prg_req = 1; bus.prg_addr = 22'h000ABC; bus.prg_we = 0; bus.prg_wdata = 0; bus.prg_allow = 1;
        bus.chr_req = 1; bus.chr_addr = 22'h200DEF; bus.chr_we = 0; bus.chr_wdata = 0; bus.chr_allow = 1;
        $display("%0t REQ prg+chr held continuously", $time);
        for (int i = 0; i < 100 && order_q.size() < n0 + 6; i++) tick();
        bus.prg_req = 0; bus.chr_req = 0;
        repeat (10) tick();
        checks++;
        if (order_q.size() < n0 + 6) begin
            errors++; $display("FAIL fair_grant_count: got %0d grants want >=6", order_q.size() - n0);
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (order_q[n0+i] !== exp_order[i]) begin
                    errors++; $display("FAIL fair_order[%0d]: got %s want %s", i,
                                       order_q[n0+i] ? "chr" : "prg", exp_order[i] ? "chr" : "prg");
                end
            end
        end
        prg_q.delete();
        chr_q.delete();
    endtask

    task automatic test_timeout();
        bit ok;
        int cnt = 0;
        int pd;
        ack_en = 0;
        drive_req(1'b1, 22'h2000F0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        wait_mem_req(ok);
        for (int i = 0; i < 300; i++) begin
            if (!bus.mem_req) break;
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (!ok || cnt != 64) begin errors++; $display("FAIL timeout_len: got %0d wait cycles want 64", cnt); end
        checks++;
        if ({bus.chr_done, bus.chr_rdata} !== {1'b1, 8'hFF}) begin
            errors++; $display("FAIL timeout_done: got done=%b rdata=%h want 1/ff", bus.chr_done, bus.chr_rdata);
        end
        checks++;
        if (bus.err_timeout !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %b want 1", bus.err_timeout); end
        ack_en = 1;
        tick();
        pd = prg_done_cnt;
        drive_req(1'b0, 22'h0003A0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        repeat (6) tick();
        checks++;
        if (prg_done_cnt != pd + 1) begin
            errors++; $display("FAIL timeout_recover: got %0d prg_done want 1", prg_done_cnt - pd);
        end
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        int cd;
        checks++;
        if ({bus.err_timeout, bus.err_overrun} !== 2'b11) begin
            errors++; $display("FAIL sticky_errs: got %b%b want 11", bus.err_timeout, bus.err_overrun);
        end
        ack_en = 0;
        drive_req(1'b0, 22'h000111, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        wait_mem_req(ok);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (!ok || bus.mem_req !== 1'b0 || bus.mem_addr !== 22'd0) begin
            errors++; $display("FAIL async_reset: got seen=%b mem_req=%b addr=%h want 1/0/0", ok, bus.mem_req, bus.mem_addr);
        end
        prg_q.delete();
        chr_q.delete();
        prg_last = 8'h00;
        chr_last = 8'h00;
        repeat (2) tick();
        reset_n = 1'b1;
        ack_en = 1;
        checks++;
        if ({bus.err_timeout, bus.err_overrun} !== 2'b00) begin
            errors++; $display("FAIL reset_clears_errs: got %b%b want 00", bus.err_timeout, bus.err_overrun);
        end
        cd = chr_done_cnt;
        drive_req(1'b1, 22'h2ABCDE, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL post_reset_grant: got mem_req=%b want 1", bus.mem_req); end
        repeat (4) tick();
        checks++;
        if (chr_done_cnt != cd + 1) begin
            errors++; $display("FAIL post_reset_done: got %0d chr_done want 1", chr_done_cnt - cd);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_chr_read();
        test_simultaneous();
        test_disallowed();
        test_overrun();
        test_fairness();
        test_timeout();
        test_reset_mid_wait();
        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mapper_mem_arb.md
Name: mapper_mem_arb

Overview:
- Downstream of the mapper address-translation stage.
- Takes the translated PRG (CPU) and CHR (PPU) 22-bit addresses the mapper produces, together with its allow qualifiers.
- Serialises them onto the single external-memory (SDRAM controller) request/ack port and returns read data to each client.
- Gives CHR priority, with a bounded-starvation guarantee for PRG, per-request timeout and sticky error flags.

Parameters:
- TIMEOUT, 64: cycles in WAIT without mem_ack before the access is aborted. Range 2..255.
- FAIR_MAX, 2: consecutive CHR grants allowed while PRG is pending before PRG is forced next. Range 1..7.
- OPEN_BUS, 8'hFF: read data returned for disallowed or aborted reads.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- prg_req  in  1  one-cycle request pulse from the CPU side.
- prg_addr  in  22  translated PRG address.
- prg_we  in  1  1 = write.
- prg_wdata  in  8  write data.
- prg_allow  in  1  mapper permits this access.
- chr_req  in  1  one-cycle request pulse from the PPU side.
- chr_addr  in  22  translated CHR address.
- chr_we  in  1  1 = write.
- chr_wdata  in  8  write data.
- chr_allow  in  1  mapper permits this access.
- prg_rdata  out  8  PRG read data, valid with prg_done.
- prg_done  out  1  one-cycle completion pulse for PRG.
- chr_rdata  out  8  CHR read data, valid with chr_done.
- chr_done  out  1  one-cycle completion pulse for CHR.
- mem_req  out  1  external request, held until ack.
- mem_addr  out  22  external address.
- mem_we  out  1  external write enable.
- mem_wdata  out  8  external write data.
- mem_ack  in  1  one-cycle acknowledge; mem_rdata valid in the same cycle.
- mem_rdata  in  8  external read data.
- err_timeout  out  1  sticky; set on any abort.
- err_overrun  out  1  sticky; set when a request arrives while the same client is already pending.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (reset_n). On reset_n=0:
  - all outputs are 0; rdata outputs are 0.
  - pending slots are cleared, FSM goes to IDLE, fairness counter is 0, timeout counter is 0.
- Capture:
  - Each client has a one-entry pending slot {addr, we, wdata, allow}, captured at the edge where its req=1.
  - A req arriving while that client's slot is already pending (or in service) is dropped: the old request is kept and err_overrun is set.
  - Both clients may request on the same edge; both are captured.
- FSM states: IDLE, WAIT.
- IDLE:
  - If no slot is pending, stay in IDLE.
  - Otherwise select a winner:
    - CHR, unless (PRG pending AND fair_cnt==FAIR_MAX), in which case PRG.
    - If only one slot is pending, that client wins.
  - Fairness counter:
    - fair_cnt increments on each CHR grant made while PRG is pending, saturating at FAIR_MAX.
    - It clears on any PRG grant.
  - Winner with allow=0: no memory access.
    - Next edge: done pulse for that client, rdata=OPEN_BUS (writes are discarded).
    - Slot clears, FSM stays in IDLE.
  - Winner with allow=1: next edge sets mem_req=1 with the registered mem_addr/mem_we/mem_wdata, and the FSM goes to WAIT.
- WAIT:
  - mem_* outputs are stable while mem_req=1.
  - At the edge where mem_ack=1:
    - mem_req goes to 0.
    - Winner rdata latches mem_rdata (writes: rdata unchanged) and done pulses for 1 cycle.
    - Slot clears, FSM goes to IDLE.
  - Timeout counter counts WAIT cycles. At count TIMEOUT without ack:
    - mem_req goes to 0 and the FSM goes to IDLE.
    - done pulses with rdata=OPEN_BUS and err_timeout is set.
  - A mem_ack seen in IDLE is ignored.
- Latency:
  - req sampled at edge E0; mem_req high after E1; ack in the following cycle gives done high after E2.
  - Minimum is therefore 2 cycles, with one IDLE bubble between consecutive memory accesses.
- New requests from the client not being served are captured during WAIT.
- Sticky errors clear only on reset.

Optional Feature:
- Macro: MAPPER_MEM_ARB_STATS_EN.
- When defined:
  - Adds outputs stat_prg_grants[15:0], stat_chr_grants[15:0] and stat_max_wait[7:0].
  - Grant counters count memory grants (allow=1) and wrap at 16'hFFFF to 0.
  - stat_max_wait is the largest WAIT cycle count seen, saturating at 255.
  - All three reset to 0.
- When undefined: these ports and registers do not exist; behaviour is otherwise identical.

Test Plan:
- Single CHR read at addr 22'h200123 with an ack the cycle after mem_req rises and mem_rdata=8'h5A: chr_done 2 cycles after req, chr_rdata=8'h5A, mem_addr=22'h200123, mem_we=0.
- prg_req and chr_req on the same edge, both allow=1: CHR is granted first, PRG second, each with exactly one done pulse.
- FAIR_MAX=2, PRG pending while CHR is re-requested continuously: grant order is CHR, CHR, PRG, CHR, CHR, PRG…
- prg_req with prg_allow=0, prg_we=1: no mem_req asserted; prg_done one cycle after capture with prg_rdata=8'hFF.
- No ack with TIMEOUT=64: mem_req drops after 64 WAIT cycles, done pulses with 8'hFF, err_timeout=1; the next request completes normally.
- Second chr_req while CHR is in WAIT: err_overrun=1 and only one chr_done occurs. reset_n pulsed low mid-WAIT: mem_req drops immediately and the FSM is in IDLE.
